// File: rtl/melody_game_pkg.sv
// Shared types and helpers for the melody memory game engine.
package melody_game_pkg;

  // Game phases: playback of the prefix, waiting for and echoing keys, end states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY_ON  = 3'd1,
    ST_PLAY_OFF = 3'd2,
    ST_WAIT_KEY = 3'd3,
    ST_ECHO     = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_t;

  // Note code that drives the piezo silent.
  localparam int unsigned SILENT = 32'd0;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, restartable by clear.
module tick_gen
  import melody_game_pkg::*;
#(
  parameter int unsigned TICK_DIV = 32'd5000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CNT_W = width_of(TICK_DIV);

  logic [CNT_W-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = (r_count == CNT_W'(TICK_DIV - 32'd1));
  assign o_tick = w_wrap;

  // Count 0..TICK_DIV-1; clear restarts the phase from zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/melody_memory_game.sv
// Memory/echo game: plays a growing melody prefix, checks keypad answers, tracks lives.
module melody_memory_game
  import melody_game_pkg::*;
#(
  parameter int unsigned NOTE_W    = 32'd3,
  parameter int unsigned MAX_LEN   = 32'd8,
  parameter int unsigned TICK_DIV  = 32'd5000000,
  parameter int unsigned ON_TICKS  = 32'd2,
  parameter int unsigned OFF_TICKS = 32'd2,
  parameter int unsigned LIVES     = 32'd3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                seq_wr_en,
  input  logic [MAX_LEN*NOTE_W-1:0]           seq_data,
  input  logic                                start,
  input  logic                                reverse_mode,
  input  logic                                key_valid,
  input  logic [NOTE_W-1:0]                   key_code,
  output logic [NOTE_W-1:0]                   tone_out,
  output logic [NOTE_W-1:0]                   led_out,
  output logic                                playing,
  output logic                                await_key,
  output logic [width_of(MAX_LEN+32'd1)-1:0]  round_len,
  output logic [width_of(LIVES+32'd1)-1:0]    miss_count,
  output logic                                win,
  output logic                                lose
);

  localparam int unsigned IDX_W  = width_of(MAX_LEN);
  localparam int unsigned RL_W   = width_of(MAX_LEN + 32'd1);
  localparam int unsigned MC_W   = width_of(LIVES + 32'd1);
  localparam int unsigned TC_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned TC_W   = width_of(TC_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NOTE_W-1:0] r_notes [MAX_LEN];
  logic              r_loaded;
  logic              r_rev;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_exp;
  logic [NOTE_W-1:0] r_key;
  logic              r_hit;
  logic [RL_W-1:0]   r_round;
  logic [MC_W-1:0]   r_miss;
  logic [TC_W-1:0]   r_tick_cnt;
  logic [NOTE_W-1:0] r_tone;
  logic              r_playing;
  logic              r_await;
  logic              r_win;
  logic              r_lose;

  logic              w_tick;
  logic              w_state_chg;
  logic              w_cmd_ok;
  logic              w_load;
  logic              w_start;
  logic              w_on_done;
  logic              w_off_done;
  logic [IDX_W-1:0]  w_last_pos;
  logic              w_last_note;
  logic              w_last_ans;
  logic              w_full;
  logic [MC_W-1:0]   w_miss_inc;
  logic              w_lose_now;

  // Every state entry restarts both the prescaler and the per-phase tick count.
  assign w_state_chg = (w_state_nxt != r_state);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (w_state_chg),
    .o_tick  (w_tick)
  );

  // Load and start are only honoured between games; a load wins over start.
  assign w_cmd_ok    = (r_state == ST_IDLE) || (r_state == ST_WIN) || (r_state == ST_LOSE);
  assign w_load      = w_cmd_ok && seq_wr_en;
  assign w_start     = w_cmd_ok && start && !seq_wr_en && r_loaded;
  assign w_on_done   = w_tick && (r_tick_cnt == TC_W'(ON_TICKS - 32'd1));
  assign w_off_done  = w_tick && (r_tick_cnt == TC_W'(OFF_TICKS - 32'd1));
  assign w_last_pos  = IDX_W'(r_round - RL_W'(1));
  assign w_last_note = (r_idx == w_last_pos);
  assign w_last_ans  = r_rev ? (r_exp == IDX_W'(0)) : (r_exp == w_last_pos);
  assign w_full      = (r_round == RL_W'(MAX_LEN));
  assign w_miss_inc  = r_miss + MC_W'(1);
  assign w_lose_now  = (w_miss_inc == MC_W'(LIVES));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision for the game phases.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (w_start) w_state_nxt = ST_PLAY_ON;
        else         w_state_nxt = r_state;
      end
      ST_PLAY_ON: begin
        if (w_on_done) w_state_nxt = ST_PLAY_OFF;
        else           w_state_nxt = r_state;
      end
      ST_PLAY_OFF: begin
        if (w_off_done) begin
          if (w_last_note) w_state_nxt = ST_WAIT_KEY;
          else             w_state_nxt = ST_PLAY_ON;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_WAIT_KEY: begin
        if (key_valid) w_state_nxt = ST_ECHO;
        else           w_state_nxt = r_state;
      end
      ST_ECHO: begin
        if (w_on_done) begin
          if (r_hit) begin
            if (!w_last_ans) w_state_nxt = ST_WAIT_KEY;
            else if (w_full) w_state_nxt = ST_WIN;
            else             w_state_nxt = ST_PLAY_ON;
          end else begin
            if (w_lose_now) w_state_nxt = ST_LOSE;
            else            w_state_nxt = ST_PLAY_ON;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Ticks elapsed within the current phase.
  always_ff @(posedge clk) begin
    if (reset || w_state_chg) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + TC_W'(1);
    end
  end

  // Melody store, round/miss bookkeeping and playback/answer pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) r_notes[i] <= '0;
      r_loaded <= 1'b0;
      r_rev    <= 1'b0;
      r_idx    <= '0;
      r_exp    <= '0;
      r_key    <= '0;
      r_hit    <= 1'b0;
      r_round  <= '0;
      r_miss   <= '0;
    end else begin
      if (w_load) begin
        for (int i = 0; i < MAX_LEN; i++) r_notes[i] <= seq_data[i*NOTE_W +: NOTE_W];
        r_loaded <= 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (w_start) begin
            r_round <= RL_W'(1);
            r_miss  <= '0;
            r_rev   <= reverse_mode;
            r_idx   <= '0;
          end
        end
        ST_PLAY_OFF: begin
          if (w_off_done) begin
            if (w_last_note) r_exp <= r_rev ? w_last_pos : IDX_W'(0);
            else             r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_WAIT_KEY: begin
          if (key_valid) begin
            r_key <= key_code;
            r_hit <= (key_code == r_notes[r_exp]);
          end
        end
        ST_ECHO: begin
          if (w_on_done) begin
            if (r_hit) begin
              if (!w_last_ans) begin
                r_exp <= r_rev ? (r_exp - IDX_W'(1)) : (r_exp + IDX_W'(1));
              end else if (!w_full) begin
                r_round <= r_round + RL_W'(1);
                r_idx   <= '0;
              end
            end else begin
              r_miss <= w_miss_inc;
              r_idx  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs follow the state one cycle after entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tone    <= NOTE_W'(SILENT);
      r_playing <= 1'b0;
      r_await   <= 1'b0;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
    end else begin
      r_playing <= (r_state == ST_PLAY_ON) || (r_state == ST_PLAY_OFF);
      r_await   <= (r_state == ST_WAIT_KEY);
      r_win     <= (r_state == ST_WIN);
      r_lose    <= (r_state == ST_LOSE);
      case (r_state)
        ST_PLAY_ON: r_tone <= r_notes[r_idx];
        ST_ECHO:    r_tone <= r_key;
        default:    r_tone <= NOTE_W'(SILENT);
      endcase
    end
  end

  assign tone_out   = r_tone;
  assign led_out    = r_tone;
  assign playing    = r_playing;
  assign await_key  = r_await;
  assign round_len  = r_round;
  assign miss_count = r_miss;
  assign win        = r_win;
  assign lose       = r_lose;

endmodule

// File: tb/tb_melody_memory_game.sv
// Self-checking bench for melody_memory_game with a game-level reference model.
module tb_melody_memory_game;

  localparam int NW = 3, ML = 4, TD = 4, ON = 2, OFF = 1, LV = 2;
  localparam int ON_CYC = ON * TD;
  localparam int OFF_CYC = OFF * TD;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              seq_wr_en = 1'b0;
  logic [ML*NW-1:0]  seq_data = '0;
  logic              start = 1'b0;
  logic              reverse_mode = 1'b0;
  logic              key_valid = 1'b0;
  logic [NW-1:0]     key_code = '0;
  logic [NW-1:0]     tone_out, led_out;
  logic              playing, await_key, win, lose;
  logic [2:0]        round_len;
  logic [1:0]        miss_count;

  int total = 0;
  int bad = 0;

  // Reference model: melody, direction, round, misses, answer position.
  logic [NW-1:0] mel [ML];
  bit m_rev;
  int m_round, m_miss, m_k;
  bit m_done;

  melody_memory_game #(
    .NOTE_W(NW), .MAX_LEN(ML), .TICK_DIV(TD), .ON_TICKS(ON), .OFF_TICKS(OFF), .LIVES(LV)
  ) dut (
    .clk(clk), .reset(reset), .seq_wr_en(seq_wr_en), .seq_data(seq_data), .start(start),
    .reverse_mode(reverse_mode), .key_valid(key_valid), .key_code(key_code),
    .tone_out(tone_out), .led_out(led_out), .playing(playing), .await_key(await_key),
    .round_len(round_len), .miss_count(miss_count), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW-1:0] correct_key();
    return m_rev ? mel[m_round-1-m_k] : mel[m_k];
  endfunction

  task automatic load_melody(input logic [ML*NW-1:0] word, input bit with_start);
    seq_wr_en = 1'b1; seq_data = word; start = with_start;
    cyc();
    seq_wr_en = 1'b0; start = 1'b0;
    for (int i = 0; i < ML; i++) mel[i] = word[i*NW +: NW];
  endtask

  task automatic start_game(input bit rev);
    start = 1'b1; reverse_mode = rev;
    cyc();
    start = 1'b0;
    m_rev = rev; m_round = 1; m_miss = 0; m_k = 0; m_done = 0;
  endtask

  // Checks playback of the current prefix; optionally injects a key press and a load.
  task automatic check_playback(input bit inject);
    logic [NW-1:0] exp_t;
    logic [ML*NW-1:0] other;
    for (int i = 0; i < m_round; i++) begin
      for (int c = 0; c < ON_CYC + OFF_CYC; c++) begin
        cyc();
        key_valid = 1'b0; seq_wr_en = 1'b0;
        exp_t = (c < ON_CYC) ? mel[i] : 3'd0;
        total++;
        if (tone_out !== exp_t || led_out !== exp_t || playing !== 1'b1) begin
          bad++;
          $display("FAIL playback note%0d cyc%0d: tone=%0d led=%0d playing=%0b, want tone=%0d playing=1",
                   i, c, tone_out, led_out, playing, exp_t);
        end
        if (inject && i == 0 && c == 2) begin
          for (int j = 0; j < ML; j++) other[j*NW +: NW] = ~mel[j];
          key_valid = 1'b1; key_code = ~mel[0];
          seq_wr_en = 1'b1; seq_data = other;
        end
      end
    end
    cyc();
    total++;
    if (await_key !== 1'b1 || tone_out !== 3'd0 || playing !== 1'b0 ||
        round_len !== 3'(m_round) || miss_count !== 2'(m_miss)) begin
      bad++;
      $display("FAIL await_after_play: await=%0b tone=%0d playing=%0b round=%0d miss=%0d, want 1 0 0 %0d %0d",
               await_key, tone_out, playing, round_len, miss_count, m_round, m_miss);
    end
  endtask

  // Presses a key and checks it is echoed for the ON phase; optionally injects a stray key.
  task automatic press_and_echo(input logic [NW-1:0] key, input bit inject);
    key_valid = 1'b1; key_code = key;
    cyc();
    key_valid = 1'b0;
    for (int c = 0; c < ON_CYC; c++) begin
      cyc();
      key_valid = 1'b0;
      total++;
      if (tone_out !== key || led_out !== key || await_key !== 1'b0) begin
        bad++;
        $display("FAIL echo cyc%0d: tone=%0d led=%0d await=%0b, want tone=%0d await=0",
                 c, tone_out, led_out, await_key, key);
      end
      if (inject && c == 2) begin
        key_valid = 1'b1; key_code = key + 3'd1;
      end
    end
  endtask

  // One answer: predicted outcome from the game rules, then the follow-up phase is checked.
  task automatic answer(input logic [NW-1:0] key, input bit inject);
    logic [NW-1:0] want;
    want = correct_key();
    press_and_echo(key, inject);
    if (key == want) begin
      if (m_k == m_round - 1) begin
        m_k = 0;
        if (m_round == ML) begin
          cyc();
          m_done = 1;
          total++;
          if (win !== 1'b1 || lose !== 1'b0 || tone_out !== 3'd0 || playing !== 1'b0 || round_len !== 3'(ML)) begin
            bad++;
            $display("FAIL win_state: win=%0b lose=%0b tone=%0d playing=%0b round=%0d, want 1 0 0 0 %0d",
                     win, lose, tone_out, playing, round_len, ML);
          end
        end else begin
          m_round++;
          check_playback(1'b0);
        end
      end else begin
        m_k++;
        cyc();
        total++;
        if (await_key !== 1'b1 || tone_out !== 3'd0) begin
          bad++;
          $display("FAIL next_answer: await=%0b tone=%0d, want 1 0", await_key, tone_out);
        end
      end
    end else begin
      m_miss++;
      m_k = 0;
      if (m_miss == LV) begin
        cyc();
        m_done = 1;
        total++;
        if (lose !== 1'b1 || win !== 1'b0 || miss_count !== 2'(LV) || tone_out !== 3'd0) begin
          bad++;
          $display("FAIL lose_state: lose=%0b win=%0b miss=%0d tone=%0d, want 1 0 %0d 0",
                   lose, win, miss_count, tone_out, LV);
        end
      end else begin
        check_playback(1'b0);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    total++;
    if (tone_out !== 3'd0 || led_out !== 3'd0 || playing !== 1'b0 || await_key !== 1'b0 ||
        round_len !== 3'd0 || miss_count !== 2'd0 || win !== 1'b0 || lose !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: tone=%0d led=%0d pl=%0b aw=%0b rl=%0d mc=%0d w=%0b l=%0b, want all 0",
               tone_out, led_out, playing, await_key, round_len, miss_count, win, lose);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    total++;
    if (playing !== 1'b0 || round_len !== 3'd0 || tone_out !== 3'd0) begin
      bad++;
      $display("FAIL start_unloaded: playing=%0b round=%0d tone=%0d, want 0 0 0", playing, round_len, tone_out);
    end
  endtask

  task automatic test_first_round();
    load_melody({3'd4, 3'd3, 3'd2, 3'd1}, 1'b0);
    start_game(1'b0);
    check_playback(1'b0);
  endtask

  task automatic test_forward_win();
    for (int n = 0; n < 40 && !m_done; n++) answer(correct_key(), 1'b0);
    cyc(); cyc(); cyc();
    total++;
    if (win !== 1'b1 || tone_out !== 3'd0 || round_len !== 3'd4) begin
      bad++;
      $display("FAIL win_hold: win=%0b tone=%0d round=%0d, want 1 0 4", win, tone_out, round_len);
    end
  endtask

  task automatic test_reverse();
    load_melody({3'd4, 3'd3, 3'd2, 3'd1}, 1'b0);
    start_game(1'b1);
    check_playback(1'b0);
    answer(3'd1, 1'b0);
    answer(3'd2, 1'b0);
    answer(3'd1, 1'b0);
    total++;
    if (round_len !== 3'd3 || miss_count !== 2'd0) begin
      bad++;
      $display("FAIL reverse_hit: round=%0d miss=%0d, want 3 0", round_len, miss_count);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    load_melody({3'd4, 3'd3, 3'd2, 3'd1}, 1'b0);
    start_game(1'b1);
    check_playback(1'b0);
    answer(3'd1, 1'b0);
    answer(3'd1, 1'b0);
    total++;
    if (miss_count !== 2'd1 || round_len !== 3'd2) begin
      bad++;
      $display("FAIL reverse_miss: miss=%0d round=%0d, want 1 2", miss_count, round_len);
    end
  endtask

  task automatic test_lose();
    answer(3'd4, 1'b0);
    key_valid = 1'b1; key_code = 3'd2;
    cyc();
    key_valid = 1'b0;
    cyc(); cyc();
    total++;
    if (lose !== 1'b1 || miss_count !== 2'd2 || tone_out !== 3'd0 || await_key !== 1'b0) begin
      bad++;
      $display("FAIL lose_key_ignored: lose=%0b miss=%0d tone=%0d await=%0b, want 1 2 0 0",
               lose, miss_count, tone_out, await_key);
    end
    start_game(1'b0);
    check_playback(1'b0);
    total++;
    if (round_len !== 3'd1 || miss_count !== 2'd0 || lose !== 1'b0) begin
      bad++;
      $display("FAIL restart: round=%0d miss=%0d lose=%0b, want 1 0 0", round_len, miss_count, lose);
    end
  endtask

  task automatic test_ignored_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    load_melody({3'd6, 3'd5, 3'd7, 3'd3}, 1'b0);
    start_game(1'b0);
    check_playback(1'b1);
    answer(correct_key(), 1'b1);
    answer(correct_key(), 1'b0);
    answer(correct_key(), 1'b1);
  endtask

  task automatic test_reset_mid_echo();
    key_valid = 1'b1; key_code = correct_key();
    cyc();
    key_valid = 1'b0;
    cyc(); cyc(); cyc();
    reset = 1'b1; key_valid = 1'b1; key_code = 3'd5;
    cyc();
    reset = 1'b0; key_valid = 1'b0;
    total++;
    if (tone_out !== 3'd0 || led_out !== 3'd0 || playing !== 1'b0 || await_key !== 1'b0 ||
        round_len !== 3'd0 || miss_count !== 2'd0 || win !== 1'b0 || lose !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_echo: tone=%0d pl=%0b aw=%0b rl=%0d mc=%0d w=%0b l=%0b, want all 0",
               tone_out, playing, await_key, round_len, miss_count, win, lose);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    total++;
    if (playing !== 1'b0 || round_len !== 3'd0) begin
      bad++;
      $display("FAIL start_after_reset: playing=%0b round=%0d, want 0 0", playing, round_len);
    end
  endtask

  task automatic test_random_games();
    logic [ML*NW-1:0] word;
    logic [NW-1:0] k;
    for (int g = 0; g < 6; g++) begin
      for (int j = 0; j < ML; j++) word[j*NW +: NW] = 3'($urandom_range(1, 7));
      load_melody(word, 1'b1);
      cyc(); cyc();
      total++;
      if (playing !== 1'b0) begin
        bad++;
        $display("FAIL load_with_start game%0d: playing=%0b, want 0", g, playing);
      end
      start_game(1'($urandom_range(0, 1)));
      check_playback(1'b0);
      for (int n = 0; n < 60 && !m_done; n++) begin
        k = correct_key();
        if ($urandom_range(0, 4) == 0) k = k ^ 3'($urandom_range(1, 7));
        answer(k, 1'b0);
      end
      total++;
      if (m_done !== 1'b1) begin
        bad++;
        $display("FAIL game%0d_unfinished: done=%0b, want 1", g, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_forward_win();
    test_reverse();
    test_lose();
    test_ignored_inputs();
    test_reset_mid_echo();
    test_random_games();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
